// File: rtl/tri_clip_sequencer.sv
// Triangle sequencer between vertex setup and the external screen-bound clip datapath.
// Holds each triangle on the datapath for one cycle, then forwards (clamped) or culls it.
module tri_clip_sequencer (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [7:0]         cfg_frac_bits,
    input  logic [31:0]        cfg_max_width,
    input  logic [31:0]        cfg_max_height,
    input  logic               cfg_cull_en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [47:0] in_fx1,
    input  logic signed [47:0] in_fy1,
    input  logic signed [47:0] in_fx2,
    input  logic signed [47:0] in_fy2,
    input  logic signed [47:0] in_fx3,
    input  logic signed [47:0] in_fy3,
    output logic signed [47:0] clip_fx1,
    output logic signed [47:0] clip_fy1,
    output logic signed [47:0] clip_fx2,
    output logic signed [47:0] clip_fy2,
    output logic signed [47:0] clip_fx3,
    output logic signed [47:0] clip_fy3,
    output logic [7:0]         clip_frac_bits,
    output logic [31:0]        clip_max_width,
    output logic [31:0]        clip_max_height,
    input  logic signed [47:0] clip_fx1_c,
    input  logic signed [47:0] clip_fy1_c,
    input  logic signed [47:0] clip_fx2_c,
    input  logic signed [47:0] clip_fy2_c,
    input  logic signed [47:0] clip_fx3_c,
    input  logic signed [47:0] clip_fy3_c,
    input  logic               clip_visible,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [47:0] out_fx1,
    output logic signed [47:0] out_fy1,
    output logic signed [47:0] out_fx2,
    output logic signed [47:0] out_fy2,
    output logic signed [47:0] out_fx3,
    output logic signed [47:0] out_fy3,
    output logic               out_visible,
    output logic               busy,
    output logic [15:0]        cnt_in,
    output logic [15:0]        cnt_culled,
    output logic [15:0]        cnt_out
);

    typedef enum logic [1:0] {S_IDLE, S_CLIP, S_OUT} state_e;

    typedef struct packed {
        logic [7:0]  frac;
        logic [31:0] w;
        logic [31:0] h;
        logic        cull;
    } cfg_t;

    typedef logic [5:0][47:0] tri_t;

    state_e      state_q, state_d;
    logic        pending_q, pending_d;
    cfg_t        stage_q, stage_d;
    cfg_t        shadow_q, shadow_d;
    tri_t        clip_q, clip_d;
    tri_t        out_q, out_d;
    logic        out_vis_q, out_vis_d;
    logic [15:0] cnt_in_q, cnt_in_d;
    logic [15:0] cnt_cull_q, cnt_cull_d;
    logic [15:0] cnt_out_q, cnt_out_d;

    tri_t tri_in, tri_c;
    assign tri_in = {in_fx1, in_fy1, in_fx2, in_fy2, in_fx3, in_fy3};
    assign tri_c  = {clip_fx1_c, clip_fy1_c, clip_fx2_c, clip_fy2_c, clip_fx3_c, clip_fy3_c};

    // Handshakes are gated by reset so no transfer completes in the reset cycle.
    assign in_ready  = (state_q == S_IDLE) && !pending_q && !reset;
    assign out_valid = (state_q == S_OUT) && !reset;
    assign busy      = (state_q != S_IDLE) || pending_q;

    assign {clip_fx1, clip_fy1, clip_fx2, clip_fy2, clip_fx3, clip_fy3} = clip_q;
    assign {out_fx1, out_fy1, out_fx2, out_fy2, out_fx3, out_fy3}       = out_q;
    assign out_visible     = out_vis_q;
    assign clip_frac_bits  = shadow_q.frac;
    assign clip_max_width  = shadow_q.w;
    assign clip_max_height = shadow_q.h;
    assign cnt_in          = cnt_in_q;
    assign cnt_culled      = cnt_cull_q;
    assign cnt_out         = cnt_out_q;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        stage_d    = stage_q;
        shadow_d   = shadow_q;
        clip_d     = clip_q;
        out_d      = out_q;
        out_vis_d  = out_vis_q;
        cnt_in_d   = cnt_in_q;
        cnt_cull_d = cnt_cull_q;
        cnt_out_d  = cnt_out_q;

        // Apply first, so a load landing in the apply cycle restages and stays pending.
        if (state_q == S_IDLE && pending_q) begin
            shadow_d  = stage_q;
            pending_d = 1'b0;
        end
        if (cfg_load) begin
            pending_d = 1'b1;
            stage_d   = '{frac: cfg_frac_bits, w: cfg_max_width, h: cfg_max_height, cull: cfg_cull_en};
        end

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    clip_d   = tri_in;
                    cnt_in_d = cnt_in_q + 16'd1;
                    state_d  = S_CLIP;
                end
            end
            S_CLIP: begin
                out_d     = tri_c;
                out_vis_d = clip_visible;
                if (shadow_q.cull && !clip_visible) begin
                    cnt_cull_d = cnt_cull_q + 16'd1;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    cnt_out_d = cnt_out_q + 16'd1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pending_q  <= 1'b0;
            stage_q    <= '0;
            shadow_q   <= '0;
            clip_q     <= '0;
            out_q      <= '0;
            out_vis_q  <= 1'b0;
            cnt_in_q   <= '0;
            cnt_cull_q <= '0;
            cnt_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            stage_q    <= stage_d;
            shadow_q   <= shadow_d;
            clip_q     <= clip_d;
            out_q      <= out_d;
            out_vis_q  <= out_vis_d;
            cnt_in_q   <= cnt_in_d;
            cnt_cull_q <= cnt_cull_d;
            cnt_out_q  <= cnt_out_d;
        end
    end

endmodule

// File: tb/tb_tri_clip_sequencer.sv
// Bench for tri_clip_sequencer: directed scenarios plus random traffic, with a
// scoreboard fed at accept time and drained by a monitor on the output handshake.
module tb_tri_clip_sequencer;

    typedef logic [5:0][47:0] tri_t;
    typedef struct packed {
        logic [7:0]  frac;
        logic [31:0] w;
        logic [31:0] h;
        logic        cull;
    } cfg_t;
    typedef struct {
        tri_t        c;
        logic        vis;
        int unsigned acc;
    } exp_t;

    logic clock = 1'b0, reset;
    logic cfg_load, cfg_cull_en, in_valid, in_ready, clip_visible;
    logic out_valid, out_ready, out_visible, busy;
    logic [7:0]  cfg_frac_bits, clip_frac_bits;
    logic [31:0] cfg_max_width, cfg_max_height, clip_max_width, clip_max_height;
    logic signed [47:0] in_fx1, in_fy1, in_fx2, in_fy2, in_fx3, in_fy3;
    logic signed [47:0] clip_fx1, clip_fy1, clip_fx2, clip_fy2, clip_fx3, clip_fy3;
    logic signed [47:0] clip_fx1_c, clip_fy1_c, clip_fx2_c, clip_fy2_c, clip_fx3_c, clip_fy3_c;
    logic signed [47:0] out_fx1, out_fy1, out_fx2, out_fy2, out_fx3, out_fy3;
    logic [15:0] cnt_in, cnt_culled, cnt_out;

    int unsigned n_vec = 0, n_err = 0, cyc = 0;
    int unsigned n_in = 0, n_cull = 0, n_out = 0;
    cfg_t        mcfg = '0;
    exp_t        sb[$];
    logic        acc_seen = 1'b0, first = 1'b1, rdy_rand = 1'b0;

    tri_clip_sequencer dut (
        .clock(clock), .reset(reset), .cfg_load(cfg_load),
        .cfg_frac_bits(cfg_frac_bits), .cfg_max_width(cfg_max_width),
        .cfg_max_height(cfg_max_height), .cfg_cull_en(cfg_cull_en),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fx1(in_fx1), .in_fy1(in_fy1), .in_fx2(in_fx2), .in_fy2(in_fy2),
        .in_fx3(in_fx3), .in_fy3(in_fy3),
        .clip_fx1(clip_fx1), .clip_fy1(clip_fy1), .clip_fx2(clip_fx2),
        .clip_fy2(clip_fy2), .clip_fx3(clip_fx3), .clip_fy3(clip_fy3),
        .clip_frac_bits(clip_frac_bits), .clip_max_width(clip_max_width),
        .clip_max_height(clip_max_height),
        .clip_fx1_c(clip_fx1_c), .clip_fy1_c(clip_fy1_c), .clip_fx2_c(clip_fx2_c),
        .clip_fy2_c(clip_fy2_c), .clip_fx3_c(clip_fx3_c), .clip_fy3_c(clip_fy3_c),
        .clip_visible(clip_visible),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_fx1(out_fx1), .out_fy1(out_fy1), .out_fx2(out_fx2), .out_fy2(out_fy2),
        .out_fx3(out_fx3), .out_fy3(out_fy3), .out_visible(out_visible),
        .busy(busy), .cnt_in(cnt_in), .cnt_culled(cnt_culled), .cnt_out(cnt_out)
    );

    // External clip datapath: clamp to [0, bound << frac]; invisible when fx1 and fy1 both have bit 3 set.
    function automatic logic [47:0] clampc(input logic signed [47:0] v, input logic [31:0] bnd,
                                           input logic [7:0] fb);
        longint lim, x;
        lim = longint'({32'b0, bnd}) <<< fb;
        x   = longint'(v);
        if (x < 0) x = 0;
        else if (x > lim) x = lim;
        return x[47:0];
    endfunction

    function automatic logic vis_of(input logic [47:0] fx1, input logic [47:0] fy1);
        return !(fx1[3] && fy1[3]);
    endfunction

    assign clip_fx1_c   = clampc(clip_fx1, clip_max_width, clip_frac_bits);
    assign clip_fx2_c   = clampc(clip_fx2, clip_max_width, clip_frac_bits);
    assign clip_fx3_c   = clampc(clip_fx3, clip_max_width, clip_frac_bits);
    assign clip_fy1_c   = clampc(clip_fy1, clip_max_height, clip_frac_bits);
    assign clip_fy2_c   = clampc(clip_fy2, clip_max_height, clip_frac_bits);
    assign clip_fy3_c   = clampc(clip_fy3, clip_max_height, clip_frac_bits);
    assign clip_visible = vis_of(clip_fx1, clip_fy1);

    initial forever #5 clock = ~clock;
    initial forever begin @(posedge clock); cyc++; end

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor + reference model: a triangle accepted at an edge uses the last config
    // loaded at a strictly earlier edge; culled triangles never reach the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
            mcfg = '0; n_in = 0; n_cull = 0; n_out = 0; first = 1'b1;
        end else begin
            if (in_valid && in_ready) begin
                exp_t e;
                logic v;
                acc_seen = 1'b1;
                n_in++;
                v = vis_of(in_fx1, in_fy1);
                if (mcfg.cull && !v) n_cull++;
                else begin
                    e.c   = {clampc(in_fx1, mcfg.w, mcfg.frac), clampc(in_fy1, mcfg.h, mcfg.frac),
                             clampc(in_fx2, mcfg.w, mcfg.frac), clampc(in_fy2, mcfg.h, mcfg.frac),
                             clampc(in_fx3, mcfg.w, mcfg.frac), clampc(in_fy3, mcfg.h, mcfg.frac)};
                    e.vis = v;
                    e.acc = cyc;
                    sb.push_back(e);
                end
            end
            if (cfg_load) mcfg = '{frac: cfg_frac_bits, w: cfg_max_width, h: cfg_max_height, cull: cfg_cull_en};
            if (out_valid) begin
                chk("in_ready_low_in_out", 288'(in_ready), 288'(0));
                if (sb.size() == 0) chk("unexpected_out_valid", 288'(out_valid), 288'(0));
                else begin
                    chk("out_coords", {out_fx1, out_fy1, out_fx2, out_fy2, out_fx3, out_fy3}, sb[0].c);
                    chk("out_visible", 288'(out_visible), 288'(sb[0].vis));
                    if (first) chk("latency", 288'(cyc - sb[0].acc), 288'(2));
                    first = 1'b0;
                    if (out_ready) begin
                        void'(sb.pop_front());
                        n_out++;
                        first = 1'b1;
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clock); #1;
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    function automatic tri_t mk(input int x1, input int y1, input int x2, input int y2,
                                input int x3, input int y3);
        tri_t t;
        t[5] = 48'(longint'(x1) * 65536); t[4] = 48'(longint'(y1) * 65536);
        t[3] = 48'(longint'(x2) * 65536); t[2] = 48'(longint'(y2) * 65536);
        t[1] = 48'(longint'(x3) * 65536); t[0] = 48'(longint'(y3) * 65536);
        return t;
    endfunction

    function automatic tri_t rnd_tri();
        tri_t t;
        for (int i = 0; i < 6; i++)
            t[i] = 48'((longint'($urandom_range(0, 1200)) - 100) * 65536 + longint'($urandom_range(0, 65535)));
        return t;
    endfunction

    task automatic set_cfg(input logic [7:0] f, input logic [31:0] w, input logic [31:0] h, input logic c);
        cfg_frac_bits = f; cfg_max_width = w; cfg_max_height = h; cfg_cull_en = c;
    endtask

    task automatic cfg_pulse(input logic [7:0] f, input logic [31:0] w, input logic [31:0] h, input logic c);
        set_cfg(f, w, h, c);
        cfg_load = 1'b1;
        @(posedge clock); #1;
        cfg_load = 1'b0;
    endtask

    // Returns at accept edge + 1; optionally pulses cfg_load together with the first in_valid cycle.
    task automatic send(input tri_t t, input logic with_cfg);
        int unsigned n = 0;
        {in_fx1, in_fy1, in_fx2, in_fy2, in_fx3, in_fy3} = t;
        acc_seen = 1'b0;
        in_valid = 1'b1;
        if (with_cfg) begin
            set_cfg(8'($urandom_range(8, 16)), $urandom_range(100, 1000), $urandom_range(100, 1000), 1'($urandom));
            cfg_load = 1'b1;
        end
        while (!acc_seen && n < 200) begin
            @(posedge clock); #1;
            cfg_load = 1'b0;
            n++;
        end
        in_valid = 1'b0;
        if (!acc_seen) chk("accept_timeout", 288'(0), 288'(1));
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((sb.size() != 0 || busy) && n < 1000) begin @(negedge clock); n++; end
        if (n >= 1000) chk("drain_timeout", 288'(sb.size()), 288'(0));
    endtask

    tri_t culled_t;

    initial begin
        reset = 1'b1; cfg_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_cfg('0, '0, '0, 1'b0);
        {in_fx1, in_fy1, in_fx2, in_fy2, in_fx3, in_fy3} = '0;
        repeat (3) @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_in_ready", 288'(in_ready), 288'(1));
        chk("rst_out_valid", 288'(out_valid), 288'(0));
        chk("rst_busy", 288'(busy), 288'(0));
        chk("rst_counters", {cnt_in, cnt_culled, cnt_out}, 288'(0));
        chk("rst_shadow", {clip_frac_bits, clip_max_width, clip_max_height}, 288'(0));
        chk("rst_out_regs", {out_fx1, out_fy1, out_fx2, out_fy2, out_fx3, out_fy3, out_visible}, 288'(0));

        // Pass-through
        @(posedge clock); #1;
        cfg_pulse(8'd16, 32'd640, 32'd480, 1'b1);
        @(negedge clock);
        chk("pending_busy", 288'(busy), 288'(1));
        chk("pending_blocks_accept", 288'(in_ready), 288'(0));
        @(posedge clock); #1;
        send(mk(10, 10, 100, 10, 50, 80), 1'b0);
        drain();
        chk("pass_cnts", {cnt_in, cnt_out, cnt_culled}, {16'd1, 16'd1, 16'd0});
        chk("pass_width", 288'(clip_max_width), 288'(640));

        // Cull, then cull disabled
        culled_t    = mk(10, 10, 700, 10, 50, 500);
        culled_t[5] = culled_t[5] + 48'd8;
        culled_t[4] = culled_t[4] + 48'd8;
        @(posedge clock); #1;
        send(culled_t, 1'b0);
        @(posedge clock);
        @(negedge clock);
        chk("cull_in_ready_n2", 288'(in_ready), 288'(1));
        chk("cull_no_out_valid", 288'(out_valid), 288'(0));
        chk("cull_cnt", 288'(cnt_culled), 288'(1));
        @(posedge clock); #1;
        cfg_pulse(8'd16, 32'd640, 32'd480, 1'b0);
        send(culled_t, 1'b0);
        drain();
        chk("nocull_cnts", {cnt_in, cnt_out, cnt_culled}, {16'd3, 16'd2, 16'd1});

        // Backpressure
        @(posedge clock); #1;
        out_ready = 1'b0;
        send(mk(20, 30, 40, 50, 60, 470), 1'b0);
        repeat (6) begin
            @(negedge clock);
            chk("bp_in_ready", 288'(in_ready), 288'(0));
            chk("bp_cnt_out", 288'(cnt_out), 288'(n_out[15:0]));
        end
        chk("bp_out_valid", 288'(out_valid), 288'(1));
        @(posedge clock); #1;
        out_ready = 1'b1;
        @(posedge clock); #1;
        chk("bp_release_cnt_out", 288'(cnt_out), 288'(16'd3));

        // Config change while in OUT
        out_ready = 1'b0;
        send(mk(500, 30, 400, 50, 60, 70), 1'b0);
        @(posedge clock); #1;
        cfg_pulse(8'd16, 32'd320, 32'd480, 1'b0);
        repeat (3) begin
            @(negedge clock);
            chk("cfg_hold_width", 288'(clip_max_width), 288'(640));
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("cfg_apply_blocks", 288'(in_ready), 288'(0));
        chk("cfg_apply_width_old", 288'(clip_max_width), 288'(640));
        @(negedge clock);
        chk("cfg_applied_width", 288'(clip_max_width), 288'(320));
        chk("cfg_applied_ready", 288'(in_ready), 288'(1));
        @(posedge clock); #1;
        send(mk(500, 30, 400, 50, 60, 70), 1'b0);
        drain();

        // Reset while in OUT
        @(posedge clock); #1;
        out_ready = 1'b0;
        send(mk(5, 6, 7, 8, 9, 10), 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_out_out_valid", 288'(out_valid), 288'(0));
        chk("rst_out_counters", {cnt_in, cnt_culled, cnt_out}, 288'(0));
        chk("rst_out_shadow", {clip_frac_bits, clip_max_width, clip_max_height}, 288'(0));
        chk("rst_out_busy", 288'(busy), 288'(0));

        // Random traffic with random backpressure and config reloads
        @(posedge clock); #1;
        out_ready = 1'b1;
        cfg_pulse(8'd16, 32'd640, 32'd480, 1'b1);
        rdy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
            if ($urandom_range(0, 7) == 0)
                cfg_pulse(8'($urandom_range(8, 16)), $urandom_range(100, 1000), $urandom_range(100, 1000), 1'($urandom));
            send(rnd_tri(), $urandom_range(0, 9) == 0);
        end
        drain();
        rdy_rand = 1'b0;
        @(negedge clock);
        chk("final_cnt_in", 288'(cnt_in), 288'(n_in[15:0]));
        chk("final_cnt_culled", 288'(cnt_culled), 288'(n_cull[15:0]));
        chk("final_cnt_out", 288'(cnt_out), 288'(n_out[15:0]));
        chk("final_sb_empty", 288'(sb.size()), 288'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
        $fatal(1);
    end

endmodule
